word32_bits8: RTL and testbench

//   Transmit-side counterpart of bits8_32word. Takes 32-bit words with a

---
 rtl/word32_bits8_pkg.sv | 29 ++
 rtl/word32_bits8_hold.sv | 46 ++++
 rtl/word32_bits8.sv | 118 +++++++++++
 tb/tb_word32_bits8.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/word32_bits8_pkg.sv
// Shared definitions for the 32-bit word <-> 8-bit byte lane converters.
// The receive-side deserialiser uses the same constants and state encoding.
package word32_bits8_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int CNT_W          = 2;
    localparam int SH_W           = WORD_W - BYTE_W;

    // Index of the last byte of a word on the output.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // First byte on the lane is the most significant one.
    function automatic logic [BYTE_W-1:0] msb_byte(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: BYTE_W];
    endfunction

    // Remaining bytes still to be shifted out after the first one.
    function automatic logic [SH_W-1:0] tail_bytes(input logic [WORD_W-1:0] w);
        return w[SH_W-1:0];
    endfunction

endpackage

// File: rtl/word32_bits8_hold.sv
// One-entry word holding register with a valid flag. Holds the next word
// while the current one is still being shifted out.
module word32_bits8_hold
    import word32_bits8_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    // Next value: a load wins over a clear; the two are never asserted
    // together by the serialiser because load needs an empty slot.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = data_i;
            valid_d = 1'b1;
        end else if (clear_i) begin
            word_d  = '0;
            valid_d = 1'b0;
        end
    end

    // Holding register with asynchronous clear.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = word_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/word32_bits8.sv
// Word-to-byte serialiser: accepts 32-bit words over valid/ready and emits
// four bytes per word, most significant byte first, one byte per clk_4f.
// A second word may be parked in the hold register so that back-to-back
// words leave the lane without a bubble.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | nothing on the lane, valid_out=0, Data_out=00
//   ST_SEND | byte cnt_q of the current word is on Data_out
module word32_bits8
    import word32_bits8_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] Data_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [BYTE_W-1:0] Data_out
);

    state_e             state_q, state_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pend_load, pend_clear;
    logic               pend_v;
    logic [WORD_W-1:0]  pend_word;
    logic               accept;

    // Ready depends only on registered state, never on valid_in.
    assign ready_out = !pend_v;
    assign accept    = valid_in && ready_out;

    word32_bits8_hold u_hold (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .load_i  (pend_load),
        .clear_i (pend_clear),
        .data_i  (Data_in),
        .data_o  (pend_word),
        .valid_o (pend_v)
    );

    // Next-state and datapath decisions for the byte sequencer.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        pend_load  = 1'b0;
        pend_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = msb_byte(Data_in);
                    sh_d    = tail_bytes(Data_in);
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (cnt_q != LAST_IDX) begin
                    data_d    = sh_q[SH_W-1 -: BYTE_W];
                    sh_d      = {sh_q[SH_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    cnt_d     = cnt_q + CNT_W'(1);
                    pend_load = accept;
                end else if (pend_v) begin
                    // Parked word goes straight out; ready is low on this
                    // edge so no new word can arrive at the same time.
                    data_d     = msb_byte(pend_word);
                    sh_d       = tail_bytes(pend_word);
                    cnt_d      = '0;
                    pend_clear = 1'b1;
                end else if (accept) begin
                    data_d = msb_byte(Data_in);
                    sh_d   = tail_bytes(Data_in);
                    cnt_d  = '0;
                end else begin
                    // Drop to idle with a clean zero on the lane.
                    data_d  = '0;
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                data_d  = '0;
                sh_d    = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register and output byte; reset drops any partial word.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out = (state_q == ST_SEND);
    assign Data_out  = data_q;

endmodule

// File: tb/tb_word32_bits8.sv
`timescale 1ns/100ps
module tb_word32_bits8;

    logic        clk_4f;
    logic        reset;
    logic        valid_in;
    logic [31:0] Data_in;
    logic        ready_out;
    logic        valid_out;
    logic [7:0]  Data_out;

    int checks = 0;
    int errors = 0;

    // Receive-side model: every 4 consecutive valid bytes form one word.
    logic [31:0] rx_acc;
    int          rx_cnt;
    logic [31:0] rx_words[$];

    word32_bits8 dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .Data_in   (Data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .Data_out  (Data_out)
    );

    initial clk_4f = 1'b0;
    always #1 clk_4f = ~clk_4f;

    always @(negedge clk_4f) begin
        if (!reset) begin
            rx_cnt = 0;
            rx_acc = '0;
        end else if (valid_out) begin
            rx_acc = {rx_acc[23:0], Data_out};
            rx_cnt = rx_cnt + 1;
            if (rx_cnt == 4) begin
                rx_words.push_back(rx_acc);
                rx_cnt = 0;
            end
        end
    end

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        Data_in  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_4f);
            checks++;
            if (valid_out !== 1'b0 || Data_out !== 8'h00 || ready_out !== 1'b1) begin
                errors++;
                $display("FAIL reset cyc%0d: got v=%b d=%h r=%b, want v=0 d=00 r=1",
                         i, valid_out, Data_out, ready_out);
            end
        end
        reset = 1'b1;
        @(negedge clk_4f);
    endtask

    task automatic test_single_word();
        logic [7:0] exp_d[5] = '{8'hFF, 8'hAA, 8'hFF, 8'hBB, 8'h00};
        logic       exp_v[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL single ready: got %b want 1", ready_out);
        end
        valid_in = 1'b1;
        Data_in  = 32'hFFAAFFBB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_4f);
            if (i == 0) valid_in = 1'b0;
            checks++;
            if (valid_out !== exp_v[i] || Data_out !== exp_d[i]) begin
                errors++;
                $display("FAIL single cyc%0d: got v=%b d=%h, want v=%b d=%h",
                         i, valid_out, Data_out, exp_v[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[9] = '{8'hFF, 8'hAA, 8'hFF, 8'hBB, 8'hDD, 8'hCC, 8'hDD, 8'hEE, 8'h00};
        logic       exp_v[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_r[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        valid_in = 1'b1;
        Data_in  = 32'hFFAAFFBB;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_4f);
            checks++;
            if (valid_out !== exp_v[i] || Data_out !== exp_d[i] || ready_out !== exp_r[i]) begin
                errors++;
                $display("FAIL b2b cyc%0d: got v=%b d=%h r=%b, want v=%b d=%h r=%b",
                         i, valid_out, Data_out, ready_out, exp_v[i], exp_d[i], exp_r[i]);
            end
            if (i == 0) Data_in = 32'hDDCCDDEE;
            if (i == 1) valid_in = 1'b0;
        end
    endtask

    task automatic test_idle_then_word();
        logic [7:0] exp_d[5] = '{8'h01, 8'h0F, 8'h0A, 8'h03, 8'h00};
        logic       exp_v[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_4f);
            checks++;
            if (valid_out !== 1'b0 || Data_out !== 8'h00 || ready_out !== 1'b1) begin
                errors++;
                $display("FAIL idle cyc%0d: got v=%b d=%h r=%b, want v=0 d=00 r=1",
                         i, valid_out, Data_out, ready_out);
            end
        end
        valid_in = 1'b1;
        Data_in  = 32'h010F0A03;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_4f);
            if (i == 0) valid_in = 1'b0;
            checks++;
            if (valid_out !== exp_v[i] || Data_out !== exp_d[i]) begin
                errors++;
                $display("FAIL idle_word cyc%0d: got v=%b d=%h, want v=%b d=%h",
                         i, valid_out, Data_out, exp_v[i], exp_d[i]);
            end
        end
    endtask

    // Third word held valid while ready_out=0 must be taken exactly once.
    task automatic test_hold_off();
        logic [7:0] exp_d[13] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                  8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        logic       exp_r[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        valid_in = 1'b1;
        Data_in  = 32'h11223344;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_4f);
            checks++;
            if (valid_out !== (i < 12) || Data_out !== exp_d[i] || ready_out !== exp_r[i]) begin
                errors++;
                $display("FAIL holdoff cyc%0d: got v=%b d=%h r=%b, want v=%b d=%h r=%b",
                         i, valid_out, Data_out, ready_out, (i < 12), exp_d[i], exp_r[i]);
            end
            if (i == 0) Data_in = 32'h55667788;
            if (i == 1) Data_in = 32'h99AABBCC;
            if (i == 5) valid_in = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_d[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        valid_in = 1'b1;
        Data_in  = 32'hFFAAFFBB;
        @(negedge clk_4f);
        valid_in = 1'b0;
        @(negedge clk_4f);
        checks++;
        if (valid_out !== 1'b1 || Data_out !== 8'hAA) begin
            errors++;
            $display("FAIL arst pre: got v=%b d=%h, want v=1 d=aa", valid_out, Data_out);
        end
        #0.5 reset = 1'b0;
        #0.2;
        checks++;
        if (valid_out !== 1'b0 || Data_out !== 8'h00 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL arst immediate: got v=%b d=%h r=%b, want v=0 d=00 r=1",
                     valid_out, Data_out, ready_out);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_4f);
            checks++;
            if (valid_out !== 1'b0 || Data_out !== 8'h00) begin
                errors++;
                $display("FAIL arst hold cyc%0d: got v=%b d=%h, want v=0 d=00",
                         i, valid_out, Data_out);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_4f);
            checks++;
            if (valid_out !== 1'b0 || Data_out !== 8'h00) begin
                errors++;
                $display("FAIL arst after cyc%0d: got v=%b d=%h, want v=0 d=00",
                         i, valid_out, Data_out);
            end
        end
        valid_in = 1'b1;
        Data_in  = 32'h01020304;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_4f);
            if (i == 0) valid_in = 1'b0;
            checks++;
            if (valid_out !== (i < 4) || Data_out !== exp_d[i]) begin
                errors++;
                $display("FAIL arst word cyc%0d: got v=%b d=%h, want v=%b d=%h",
                         i, valid_out, Data_out, (i < 4), exp_d[i]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [31:0] exp_w[4] = '{32'hFFAAFFBB, 32'hFFAAFFBB, 32'hDDCCDDEE, 32'h010F0A03};
        logic        mismatch;
        rx_words.delete();
        test_single_word();
        test_back_to_back();
        test_idle_then_word();
        @(negedge clk_4f);
        checks++;
        if (rx_words.size() != 4) begin
            errors++;
            $display("FAIL loopback count: got %0d words, want 4", rx_words.size());
        end else begin
            mismatch = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (rx_words[i] !== exp_w[i]) begin
                    mismatch = 1'b1;
                    $display("FAIL loopback word%0d: got %h want %h", i, rx_words[i], exp_w[i]);
                end
            end
            if (mismatch) errors++;
        end
    endtask

    initial begin
        rx_cnt = 0;
        rx_acc = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_idle_then_word();
        test_hold_off();
        test_async_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
